// File: rtl/dmem_responder.sv
// Data-memory responder for the rv32i load/store port: registered request, WAIT_CYCLES of latency,
// byte-enabled write or word read, response held until accepted. Optional fault checks: DMEM_ERR_EN.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1)
// WAIT  | request latched, counting down latency
// RESP  | response valid, held until rsp_ready
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            accept, enter_resp, leave_resp;

  logic            lat_we, lat_fault;
  logic [AW-1:0]   lat_idx;
  logic [31:0]     lat_wdata;
  logic [3:0]      lat_be;

  logic            req_fault;
  logic [AW-1:0]   req_idx;
  logic            acc_we, acc_fault;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_wdata;
  logic [3:0]      acc_be;
  logic            unused_addr;

  logic [31:0]     mem [DEPTH_WORDS];

  assign req_idx     = req_addr[AW+1:2];
  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

`ifdef DMEM_ERR_EN
  assign req_fault = (req_addr[1:0] != 2'b00) ||
                     ({1'b0, req_addr} >= 33'(4 * DEPTH_WORDS));
`else
  assign req_fault = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // With zero wait the access happens on the accept edge, so use the live request then.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = req_we;
      acc_fault = req_fault;
      acc_idx   = req_idx;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_we    = lat_we;
      acc_fault = lat_fault;
      acc_idx   = lat_idx;
      acc_wdata = lat_wdata;
      acc_be    = lat_be;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    leave_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt  = IDLE;
          leave_resp = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_fault <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_we    <= req_we;
        lat_fault <= req_fault;
        lat_idx   <= req_idx;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end
      if (enter_resp) begin
        rsp_err   <= acc_fault;
        rsp_rdata <= (acc_we || acc_fault) ? 32'd0 : mem[acc_idx];
      end else if (leave_resp) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= 32'd0;
      end
    end
  end

  // Memory is not reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && acc_we && !acc_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (WAIT_CYCLES 1, 4, 0) checked against a
// scoreboard queue of expected responses.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(256),
      .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 4 : 0))
    ) u_dut (
      .clk       (clk),
      .reset     (reset[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic int wc(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int d, input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata[d], 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err[d]), 32'd0);
  endtask

  // One full transaction; hold>0 keeps rsp_ready low that many cycles while a stray request is offered.
  task automatic xact(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err,
                      input int hold);
    int n;
    exp_t e;
    logic [31:0] first_rdata;
    @(negedge clk);
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[d] && n < 40);
    chk("latency", 32'(n), 32'(wc(d) + 1));
    first_rdata = rsp_rdata[d];
    for (int i = 0; i < hold; i++) begin
      req_valid[d] = 1'b1;
      req_we[d]    = 1'b1;
      req_addr[d]  = addr;
      req_wdata[d] = 32'hFFFF_FFFF;
      req_be[d]    = 4'hF;
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_rsp_rdata", rsp_rdata[d], first_rdata);
      chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    req_valid[d] = 1'b0;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_rdata", rsp_rdata[d], e.rdata);
      chk("rsp_err", 32'(rsp_err[d]), 32'(e.err));
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    chk_idle(d, "after_rsp");
    if (hold > 0) begin
      @(negedge clk);
      chk("no_stray_rsp", 32'(rsp_valid[d]), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int pops;
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      reset[d]     = 1'b1;
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = 32'd0;
      req_wdata[d] = 32'd0;
      req_be[d]    = 4'd0;
      rsp_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) reset[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk_idle(d, "reset");

    // Word store/load, byte lanes, empty byte-enable (WAIT_CYCLES=1)
    xact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);
    xact(0, 1'b1, 32'h10, 32'h0000_AA00, 4'b0010, 32'h0, 1'b0, 0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_AAEF, 1'b0, 0);
    xact(0, 1'b1, 32'h10, 32'h1111_1111, 4'b0000, 32'h0, 1'b0, 0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_AAEF, 1'b0, 0);
    xact(0, 1'b1, 32'h44, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0, 0);
    xact(0, 1'b1, 32'h44, 32'h0077_0000, 4'b0100, 32'h0, 1'b0, 0);
    xact(0, 1'b0, 32'h44, 32'h0, 4'h0, 32'hA577_A5A5, 1'b0, 0);

    // Backpressure: stray store offered during RESP must never land
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_AAEF, 1'b0, 3);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_AAEF, 1'b0, 0);

    // Reset in WAIT drops the uncommitted store (WAIT_CYCLES=4)
    xact(1, 1'b1, 32'h10, 32'h1111_2222, 4'hF, 32'h0, 1'b0, 0);
    xact(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h1111_2222, 1'b0, 0);
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_addr[1]  = 32'h10;
    req_wdata[1] = 32'h1234_5678;
    req_be[1]    = 4'hF;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset[1] = 1'b1;
    @(negedge clk);
    chk_idle(1, "midop_reset");
    reset[1] = 1'b0;
    repeat (6) @(negedge clk);
    chk("midop_no_rsp", 32'(rsp_valid[1]), 32'd0);
    xact(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h1111_2222, 1'b0, 0);

    // WAIT_CYCLES=0: single-cycle latency and one accept every two cycles
    xact(2, 1'b1, 32'h20, 32'hCAFE_0001, 4'hF, 32'h0, 1'b0, 0);
    xact(2, 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0, 0);
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b0;
    req_addr[2]  = 32'h20;
    rsp_ready[2] = 1'b1;
    acc  = 0;
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid[2]) begin
        chk("b2b_sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("b2b_rdata", rsp_rdata[2], e.rdata);
          pops++;
        end
      end
      if (req_ready[2]) begin
        e.rdata = 32'hCAFE_0001;
        e.err   = 1'b0;
        sb.push_back(e);
        acc++;
      end
      if (i == 7) req_valid[2] = 1'b0;
      @(negedge clk);
    end
    rsp_ready[2] = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd4);
    chk("b2b_responses", 32'(pops), 32'd4);
    sb.delete();
    chk_idle(2, "b2b_end");

`ifdef DMEM_ERR_EN
    xact(0, 1'b1, 32'h0, 32'h5555_AAAA, 4'hF, 32'h0, 1'b0, 0);
    xact(0, 1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    xact(0, 1'b1, 32'h400, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b1, 0);
    xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h5555_AAAA, 1'b0, 0);
`else
    xact(0, 1'b1, 32'h400, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 0);
    xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 0);
    xact(0, 1'b0, 32'h13, 32'h0, 4'h0, 32'hDEAD_AAEF, 1'b0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
